wall_collision_checker: RTL and testbench
=========================================

Name: wall_collision_checker

Overview:
- Consumer side of wall placement: stores wall positions produced by the wall generator and answers collision queries ("does point (x,y) lie inside any wall?").
- Sits between the wall generator, which writes entries, and the player/ball motion logic, which issues queries once per frame.
- Holds up to MAX_WALLS axis-aligned WALL_W x WALL_H rectangles. Queries are resolved by a sequential scan, one entry per cycle.

Parameters:
- MAX_WALLS, 16, table depth; power of two, ≥2.
- WALL_W, 16, wall width in pixels.
- WALL_H, 16, wall height in pixels.
- IDX_W, $clog2(MAX_WALLS), derived; do not override.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- clear  in  1  empties the table and aborts any scan.
- wr_valid  in  1  write request.
- wr_x  in  10  wall top-left X.
- wr_y  in  10  wall top-left Y.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- q_valid  in  1  query request.
- q_x  in  10  query point X.
- q_y  in  10  query point Y.
- q_ready  out  1  query accepted when q_valid & q_ready.
- rsp_valid  out  1  response available.
- rsp_hit  out  1  1 = point lies inside some wall.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- count  out  IDX_W+1  number of stored walls.
- full  out  1  count == MAX_WALLS.

Behaviour:
- Reset values: state IDLE, count 0, full 0, rsp_valid 0, rsp_hit 0, scan index 0. Table contents are don't-care.
- Clock and reset: single clock Clk; Reset is asynchronous and active-high. Reset asserted mid-scan returns the block to IDLE with no response.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - q_ready = 1.
  - wr_ready = !full.
  - Query handshake: latch q_x/q_y, clear the scan index, go to SCAN.
- SCAN:
  - Examines entry idx in a single cycle.
  - Hit → latch rsp_hit=1, go to RESP.
  - idx == count → latch rsp_hit=0, go to RESP.
  - Otherwise idx++.
- RESP:
  - rsp_valid = 1; rsp_hit held stable.
  - On rsp_ready, return to IDLE.
  - rsp_ready in the same cycle rsp_valid first rises is legal.
- Query latency (handshake cycle = 0):
  - Hit on entry i → rsp_valid in cycle i+2.
  - Miss → rsp_valid in cycle count+2.
  - Empty table → rsp_valid in cycle 2, rsp_hit=0.
- Outside IDLE: wr_ready = 0 and q_ready = 0. The table is frozen during a scan.
- Hit test uses 11-bit unsigned arithmetic, so no wrap: (q_x ≥ wx) & (q_x < wx+WALL_W) & (q_y ≥ wy) & (q_y < wy+WALL_H).
- Out-of-range writes (wr_x ≥ 640 or wr_y ≥ 480) are accepted (handshake completes) but dropped; count is unchanged.
- Simultaneous write and query accepted in IDLE: the write lands first, and the scan includes the new entry.
- Duplicate wall positions are stored as separate entries.
- full:
  - full = 1 holds wr_ready low.
  - Queries remain accepted.
- clear:
  - Highest priority below Reset; acts in any state.
  - Sets count to 0 and state to IDLE; drops rsp_valid with no response.
  - A write handshake in the same cycle as clear is discarded.

Optional Feature:
- Macro WALL_HIT_INDEX_EN.
- Defined: adds output rsp_idx [IDX_W-1:0], the index of the first matching entry, valid with rsp_valid & rsp_hit. It is 0 on a miss and resets to 0.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared package wall_pkg:
  - SCREEN_MAX_X = 10'd640 and SCREEN_MAX_Y = 10'd480, also used by the wall generator.
  - Struct wall_pos_t {x[9:0], y[9:0]}.
  - Enum wall_scan_state_t {IDLE, SCAN, RESP}.
- Sub-module wall_hit_cmp: purely combinational rectangle-contains-point compare, with parameters WALL_W/WALL_H. Instantiated once in the scan path.

Test Plan:
- Reset → count=0, full=0, rsp_valid=0, q_ready=1. Query (5,5) → rsp_valid in cycle 2, rsp_hit=0.
- Write (100,200) and (300,50); query (110,215) → hit on entry 0, rsp_valid in cycle 2, rsp_hit=1 (rsp_idx=0 with WALL_HIT_INDEX_EN). Query (116,200) → miss, rsp_valid in cycle 4.
- Edge points on wall (300,50): query (300,50) → hit; (315,65) → hit; (316,50) → miss; (300,66) → miss. Wall at (630,470): query (639,479) → hit, no wrap.
- Write 16 walls → full=1, wr_ready=0. A 17th write stalls; count stays 16. Write (640,0) after clear → accepted, count stays 0.
- Assert clear during SCAN with count=10 → next cycle state IDLE, count=0, no rsp_valid pulse. Assert Reset mid-scan → same result asynchronously.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_hit stable, wr_ready=q_ready=0. Then rsp_ready=1 → IDLE next cycle.

Source files
------------

// File: rtl/wall_pkg.sv
// Shared wall definitions: screen limits, wall position payload, scan FSM states.
package wall_pkg;

  localparam logic [9:0] SCREEN_MAX_X = 10'd640;
  localparam logic [9:0] SCREEN_MAX_Y = 10'd480;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } wall_pos_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } wall_scan_state_t;

  // True when a wall's top-left corner lies on the visible screen
  function automatic logic wall_on_screen(input wall_pos_t p);
    return (p.x < SCREEN_MAX_X) && (p.y < SCREEN_MAX_Y);
  endfunction

endpackage

// File: rtl/wall_collision_checker_if.sv
// Write / query / response bus of the wall collision checker.
// Optional macro WALL_HIT_INDEX_EN adds rsp_idx (index of the first matching wall).
interface wall_collision_checker_if #(
  parameter int unsigned MAX_WALLS = 16
);
  localparam int unsigned IDX_W = $clog2(MAX_WALLS);

  logic             wr_valid;
  logic [9:0]       wr_x;
  logic [9:0]       wr_y;
  logic             wr_ready;
  logic             q_valid;
  logic [9:0]       q_x;
  logic [9:0]       q_y;
  logic             q_ready;
  logic             rsp_valid;
  logic             rsp_hit;
  logic             rsp_ready;
  logic [IDX_W:0]   count;
  logic             full;
`ifdef WALL_HIT_INDEX_EN
  logic [IDX_W-1:0] rsp_idx;
`endif

  modport master (
    output wr_valid, wr_x, wr_y, q_valid, q_x, q_y, rsp_ready,
    input  wr_ready, q_ready, rsp_valid, rsp_hit, count, full
`ifdef WALL_HIT_INDEX_EN
    , input rsp_idx
`endif
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, q_valid, q_x, q_y, rsp_ready,
    output wr_ready, q_ready, rsp_valid, rsp_hit, count, full
`ifdef WALL_HIT_INDEX_EN
    , output rsp_idx
`endif
  );

endinterface

// File: rtl/wall_hit_cmp.sv
// Combinational rectangle-contains-point test; 11-bit math so wx+WALL_W never wraps.
module wall_hit_cmp
  import wall_pkg::*;
#(
  parameter int unsigned WALL_W = 16,
  parameter int unsigned WALL_H = 16
) (
  input  wall_pos_t wall,
  input  wall_pos_t pt,
  output logic      hit_c
);

  logic [10:0] px, py, wx, wy;

  // Widen to 11 bits and compare against both rectangle edges
  always_comb begin
    px    = {1'b0, pt.x};
    py    = {1'b0, pt.y};
    wx    = {1'b0, wall.x};
    wy    = {1'b0, wall.y};
    hit_c = (px >= wx) && (px < wx + 11'(WALL_W)) &&
            (py >= wy) && (py < wy + 11'(WALL_H));
  end

endmodule

// File: rtl/wall_collision_checker.sv
// Stores wall rectangles and answers point-in-any-wall queries by a
// one-entry-per-cycle scan. Optional macro WALL_HIT_INDEX_EN adds rsp_idx.
module wall_collision_checker
  import wall_pkg::*;
#(
  parameter int unsigned MAX_WALLS = 16,
  parameter int unsigned WALL_W    = 16,
  parameter int unsigned WALL_H    = 16,
  parameter int unsigned IDX_W     = $clog2(MAX_WALLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  wall_collision_checker_if.slave  bus
);

  localparam int unsigned CNT_W = IDX_W + 1;

  wall_scan_state_t state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  wall_pos_t        qpt_q, qpt_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] hidx_q, hidx_d;
  logic             rsp_valid_q, wr_ready_q, q_ready_q, full_q;
  logic             wr_en_c;
  logic             cmp_hit_c;
  wall_pos_t        wr_pos_c;
  wall_pos_t        wall_mem [MAX_WALLS];

  assign wr_pos_c = '{x: bus.wr_x, y: bus.wr_y};

  wall_hit_cmp #(.WALL_W(WALL_W), .WALL_H(WALL_H)) u_cmp (
    .wall  (wall_mem[idx_q[IDX_W-1:0]]),
    .pt    (qpt_q),
    .hit_c (cmp_hit_c)
  );

  // Next-state: clear overrides everything; IDLE accepts writes then queries
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    qpt_d   = qpt_q;
    hit_d   = hit_q;
    hidx_d  = hidx_q;
    wr_en_c = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.wr_valid && wr_ready_q && wall_on_screen(wr_pos_c)) begin
            wr_en_c = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
          if (bus.q_valid && q_ready_q) begin
            qpt_d   = '{x: bus.q_x, y: bus.q_y};
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          // End-of-table check first so stale entries past count never hit
          if (idx_q == count_q) begin
            hit_d   = 1'b0;
            hidx_d  = '0;
            state_d = RESP;
          end else if (cmp_hit_c) begin
            hit_d   = 1'b1;
            hidx_d  = idx_q[IDX_W-1:0];
            state_d = RESP;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      qpt_q       <= '0;
      hit_q       <= 1'b0;
      hidx_q      <= '0;
      rsp_valid_q <= 1'b0;
      wr_ready_q  <= 1'b1;
      q_ready_q   <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      qpt_q       <= qpt_d;
      hit_q       <= hit_d;
      hidx_q      <= hidx_d;
      rsp_valid_q <= (state_d == RESP);
      q_ready_q   <= (state_d == IDLE);
      wr_ready_q  <= (state_d == IDLE) && (count_d != CNT_W'(MAX_WALLS));
      full_q      <= (count_d == CNT_W'(MAX_WALLS));
    end
  end

  // Wall table storage; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_en_c) wall_mem[count_q[IDX_W-1:0]] <= wr_pos_c;
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.q_ready   = q_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = hit_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
`ifdef WALL_HIT_INDEX_EN
  assign bus.rsp_idx   = hidx_q;
`else
  logic unused_hidx;
  assign unused_hidx = ^hidx_q;
`endif

endmodule

// File: tb/tb_wall_collision_checker.sv
// Directed bench for wall_collision_checker: vector table plus corner sequences.
module tb_wall_collision_checker;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  wall_collision_checker_if #(.MAX_WALLS(16)) bus ();

  wall_collision_checker #(.MAX_WALLS(16), .WALL_W(16), .WALL_H(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_q;
    int x;
    int y;
    bit hit;
    int lat;
    int idx;
    int cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int x, input int y);
    int n = 0;
    bus.wr_x     = 10'(x);
    bus.wr_y     = 10'(y);
    bus.wr_valid = 1'b1;
    while (!bus.wr_ready && n < 50) begin tick(); n++; end
    chk("wr_accept", int'(bus.wr_ready), 1);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Present a query (optionally with a write in the same cycle) until accepted
  task automatic start_query(input int x, input int y, input bit with_wr, input int wx, input int wy);
    int n = 0;
    bus.q_x     = 10'(x);
    bus.q_y     = 10'(y);
    bus.q_valid = 1'b1;
    if (with_wr) begin
      bus.wr_x     = 10'(wx);
      bus.wr_y     = 10'(wy);
      bus.wr_valid = 1'b1;
    end
    while (!bus.q_ready && n < 50) begin tick(); n++; end
    chk("q_accept", int'(bus.q_ready), 1);
    tick();
    bus.q_valid  = 1'b0;
    bus.wr_valid = 1'b0;
  endtask

  // Latency counted with the handshake cycle as 0
  task automatic wait_rsp(output int lat, output bit hit, output int idx);
    int n = 1;
    while (!bus.rsp_valid && n < 100) begin tick(); n++; end
    lat = n;
    hit = bus.rsp_hit;
`ifdef WALL_HIT_INDEX_EN
    idx = int'(bus.rsp_idx);
`else
    idx = 0;
`endif
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_query(input string name, input int x, input int y,
                           input bit ehit, input int elat, input int eidx);
    int lat, idx;
    bit hit;
    start_query(x, y, 1'b0, 0, 0);
    wait_rsp(lat, hit, idx);
    chk({name, "_lat"}, lat, elat);
    chk({name, "_hit"}, int'(hit), int'(ehit));
`ifdef WALL_HIT_INDEX_EN
    chk({name, "_idx"}, idx, eidx);
`else
    if (eidx < 0) $display("unexpected negative index");
`endif
    consume();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int lat, idx, seen;
    bit hit;

    rst = 1'b1; clear = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0;
    bus.q_valid = 1'b0; bus.q_x = '0; bus.q_y = '0;
    bus.rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_count", int'(bus.count), 0);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_q_ready", int'(bus.q_ready), 1);
    chk("rst_wr_ready", int'(bus.wr_ready), 1);

    // {is_q, x, y, hit, lat, idx, cnt}
    vecs.push_back('{1,   5,   5, 0, 2, 0, 0});
    vecs.push_back('{0, 100, 200, 0, 0, 0, 1});
    vecs.push_back('{0, 300,  50, 0, 0, 0, 2});
    vecs.push_back('{1, 110, 215, 1, 2, 0, 2});
    vecs.push_back('{1, 116, 200, 0, 4, 0, 2});
    vecs.push_back('{1, 300,  50, 1, 3, 1, 2});
    vecs.push_back('{1, 315,  65, 1, 3, 1, 2});
    vecs.push_back('{1, 316,  50, 0, 4, 0, 2});
    vecs.push_back('{1, 300,  66, 0, 4, 0, 2});
    vecs.push_back('{0, 630, 470, 0, 0, 0, 3});
    vecs.push_back('{1, 639, 479, 1, 4, 2, 3});
    vecs.push_back('{1, 645, 485, 1, 4, 2, 3});
    vecs.push_back('{1, 646, 479, 0, 5, 0, 3});
    vecs.push_back('{0, 640,   0, 0, 0, 0, 3});
    vecs.push_back('{0,   0, 480, 0, 0, 0, 3});
    vecs.push_back('{0, 300,  50, 0, 0, 0, 4});
    vecs.push_back('{1, 305,  55, 1, 3, 1, 4});
    vecs.push_back('{1,   0,   0, 0, 6, 0, 4});

    foreach (vecs[i]) begin
      if (vecs[i].is_q) begin
        run_query($sformatf("v%0d", i), vecs[i].x, vecs[i].y, vecs[i].hit, vecs[i].lat, vecs[i].idx);
      end else begin
        do_write(vecs[i].x, vecs[i].y);
      end
      chk($sformatf("v%0d_count", i), int'(bus.count), vecs[i].cnt);
    end

    // Response held off: outputs stable, bus closed
    start_query(110, 215, 1'b0, 0, 0);
    wait_rsp(lat, hit, idx);
    chk("hold_lat", lat, 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_rsp_valid", int'(bus.rsp_valid), 1);
      chk("hold_rsp_hit", int'(hit && bus.rsp_hit), 1);
      chk("hold_wr_ready", int'(bus.wr_ready), 0);
      chk("hold_q_ready", int'(bus.q_ready), 0);
    end
    consume();
    chk("hold_release_valid", int'(bus.rsp_valid), 0);
    chk("hold_release_q_ready", int'(bus.q_ready), 1);

    // Write and query in the same cycle: scan sees the new entry
    start_query(505, 405, 1'b1, 500, 400);
    wait_rsp(lat, hit, idx);
    chk("simul_lat", lat, 6);
    chk("simul_hit", int'(hit), 1);
`ifdef WALL_HIT_INDEX_EN
    chk("simul_idx", idx, 4);
`endif
    consume();
    chk("simul_count", int'(bus.count), 5);

    // Fill the table
    pulse_clear();
    chk("clr_count", int'(bus.count), 0);
    for (int i = 0; i < 16; i++) do_write(i * 20, 0);
    chk("fill_count", int'(bus.count), 16);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_wr_ready", int'(bus.wr_ready), 0);
    bus.wr_x = 10'd500; bus.wr_y = 10'd5; bus.wr_valid = 1'b1;
    tick(); tick(); tick();
    chk("stall_count", int'(bus.count), 16);
    chk("stall_wr_ready", int'(bus.wr_ready), 0);
    bus.wr_valid = 1'b0;
    run_query("full_miss", 0, 300, 1'b0, 18, 0);
    run_query("full_hit15", 305, 5, 1'b1, 17, 15);

    // Off-screen write after clear is accepted but dropped
    pulse_clear();
    chk("clr2_full", int'(bus.full), 0);
    chk("clr2_wr_ready", int'(bus.wr_ready), 1);
    do_write(640, 0);
    chk("offscreen_count", int'(bus.count), 0);

    // Clear mid-scan: back to IDLE, no response
    for (int i = 0; i < 10; i++) do_write(i * 20, 100);
    chk("ten_count", int'(bus.count), 10);
    start_query(1000, 1000, 1'b0, 0, 0);
    tick(); tick();
    chk("scan_busy", int'(bus.q_ready), 0);
    pulse_clear();
    chk("scanclr_count", int'(bus.count), 0);
    chk("scanclr_q_ready", int'(bus.q_ready), 1);
    chk("scanclr_rsp_valid", int'(bus.rsp_valid), 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin tick(); seen |= int'(bus.rsp_valid); end
    chk("scanclr_no_rsp", seen, 0);

    // Write in the same cycle as clear is discarded
    do_write(1, 1);
    chk("pre_clrwr_count", int'(bus.count), 1);
    bus.wr_x = 10'd2; bus.wr_y = 10'd2; bus.wr_valid = 1'b1; clear = 1'b1;
    tick();
    bus.wr_valid = 1'b0; clear = 1'b0;
    chk("clrwr_count", int'(bus.count), 0);

    // Asynchronous reset mid-scan
    for (int i = 0; i < 10; i++) do_write(i * 20, 100);
    start_query(1000, 1000, 1'b0, 0, 0);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("rstscan_count", int'(bus.count), 0);
    chk("rstscan_q_ready", int'(bus.q_ready), 1);
    chk("rstscan_rsp_valid", int'(bus.rsp_valid), 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin tick(); seen |= int'(bus.rsp_valid); end
    chk("rstscan_no_rsp", seen, 0);
    run_query("post_rst", 5, 5, 1'b0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
